// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-unified_mem arbiter: FSM encoding, client ids, memory widths.
// Contains no logic. No latency or backpressure applies.
package mem_arbiter_pkg;

    localparam int MEM_AW = 15;
    localparam int MEM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic CL_I = 1'b0;
    localparam logic CL_D = 1'b1;

endpackage

// File: rtl/mem_line_buf.sv
// Line buffer: assembles read beats into a line, or holds a write-back line and muxes out one beat.
// Single-cycle writes, combinational reads; the FSM paces accesses, so there is no backpressure.
module mem_line_buf
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = 2,
    parameter int BW         = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_i,
    input  logic [MEM_DW*LINE_BEATS-1:0] line_i,
    input  logic                         wr_i,
    input  logic [BW-1:0]                slot_i,
    input  logic [MEM_DW-1:0]            data_i,
    output logic [MEM_DW*LINE_BEATS-1:0] line_o,
    output logic [MEM_DW-1:0]            slice_o
);

    logic [MEM_DW-1:0] slot_q [LINE_BEATS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LINE_BEATS; k++) slot_q[k] <= '0;
        end else if (load_i) begin
            for (int k = 0; k < LINE_BEATS; k++) slot_q[k] <= line_i[MEM_DW*k +: MEM_DW];
        end else if (wr_i) begin
            slot_q[slot_i] <= data_i;
        end
    end

    always_comb begin
        line_o = '0;
        for (int k = 0; k < LINE_BEATS; k++) line_o[MEM_DW*k +: MEM_DW] = slot_q[k];
    end

    assign slice_o = slot_q[slot_i];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D line misses onto unified_mem, splitting each line into LINE_BEATS 32-bit accesses.
// Latency: 4 cycles per beat plus grant and done cycles; clients hold req until done, and no grant while mem_rdy=0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = 2,
    parameter int ARB_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [MEM_AW-1:0]            i_addr,
    output logic [MEM_DW*LINE_BEATS-1:0] i_rdata,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [MEM_AW-1:0]            d_addr,
    input  logic [MEM_DW*LINE_BEATS-1:0] d_wdata,
    output logic [MEM_DW*LINE_BEATS-1:0] d_rdata,
    output logic                         d_done,
    output logic [MEM_AW-1:0]            mem_addr,
    output logic                         mem_re,
    output logic                         mem_we,
    output logic [MEM_DW-1:0]            mem_wdata,
    input  logic [MEM_DW-1:0]            mem_rd_data,
    input  logic                         mem_rdy
);

    localparam int LW = MEM_DW * LINE_BEATS;
    localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [MEM_AW-1:0] LOW_MASK  = MEM_AW'(LINE_BEATS - 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_BEATS - 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              client_q, client_d;
    logic              we_q, we_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic              last_q, last_d;
    logic              pick;
    logic              buf_load, buf_wr;
    logic [MEM_DW-1:0] slice;
    logic [LW-1:0]     line;

    // last_q is the most recently granted client; on contention round-robin serves the other one.
    always_comb begin
        if (i_req && d_req) pick = (ARB_MODE == 0) ? CL_D : ~last_q;
        else                pick = d_req ? CL_D : CL_I;
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        client_d = client_q;
        we_d     = we_q;
        base_d   = base_q;
        last_d   = last_q;
        buf_load = 1'b0;
        buf_wr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((i_req || d_req) && mem_rdy) begin
                    client_d = pick;
                    last_d   = pick;
                    we_d     = (pick == CL_D) && d_we;
                    base_d   = ((pick == CL_D) ? d_addr : i_addr) & ~LOW_MASK;
                    buf_load = (pick == CL_D) && d_we;
                    beat_d   = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rdy) begin
                    buf_wr = ~we_q;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            client_q <= CL_I;
            we_q     <= 1'b0;
            base_q   <= '0;
            last_q   <= CL_I;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            client_q <= client_d;
            we_q     <= we_d;
            base_q   <= base_d;
            last_q   <= last_d;
        end
    end

    // The write-back line is copied in at grant so later d_wdata changes cannot leak into the line.
    mem_line_buf #(
        .LINE_BEATS (LINE_BEATS),
        .BW         (BW)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .line_i  (d_wdata),
        .wr_i    (buf_wr),
        .slot_i  (beat_q),
        .data_i  (mem_rd_data),
        .line_o  (line),
        .slice_o (slice)
    );

    assign mem_addr  = base_q | (MEM_AW'(beat_q) & LOW_MASK);
    assign mem_re    = (state_q == ST_ISSUE) && !we_q;
    assign mem_we    = (state_q == ST_ISSUE) && we_q;
    assign mem_wdata = (we_q && (state_q == ST_ISSUE || state_q == ST_WAIT)) ? slice : '0;
    assign i_done    = (state_q == ST_DONE) && (client_q == CL_I);
    assign d_done    = (state_q == ST_DONE) && (client_q == CL_D);
    assign i_rdata   = line;
    assign d_rdata   = line;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (fixed priority and round-robin), each with a 4-clock unified_mem model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i_req, d_req, d_we, i_done, d_done;
    logic [14:0] i_addr, d_addr;
    logic [63:0] d_wdata, i_rdata, d_rdata;
    logic        i_req1, d_req1, d_we1, i_done1, d_done1;
    logic [14:0] i_addr1, d_addr1;
    logic [63:0] d_wdata1, i_rdata1, d_rdata1;

    logic [1:0]       m_re, m_we, m_rdy;
    logic [1:0][14:0] m_addr;
    logic [1:0][31:0] m_wdata, m_rd;

    mem_arbiter #(.LINE_BEATS(2), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(m_addr[0]), .mem_re(m_re[0]), .mem_we(m_we[0]), .mem_wdata(m_wdata[0]),
        .mem_rd_data(m_rd[0]), .mem_rdy(m_rdy[0])
    );

    mem_arbiter #(.LINE_BEATS(2), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_done(d_done1),
        .mem_addr(m_addr[1]), .mem_re(m_re[1]), .mem_we(m_we[1]), .mem_wdata(m_wdata[1]),
        .mem_rd_data(m_rd[1]), .mem_rdy(m_rdy[1])
    );

    function automatic logic [31:0] pat(input logic [14:0] a);
        return 32'h1000_0000 + 32'(a) * 32'd3;
    endfunction

    // unified_mem: accepts re/we when idle, rdy low for two cycles, back high with data in the 4th cycle.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        logic [31:0] mem [1024];
        logic [1:0]  cnt;
        logic [31:0] rdq;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= 2'd0;
                rdq <= 32'd0;
                for (int a = 0; a < 1024; a++) mem[a] <= pat(15'(a));
            end else if (cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end else if (m_re[g] || m_we[g]) begin
                cnt <= 2'd2;
                if (m_we[g]) mem[m_addr[g][9:0]] <= m_wdata[g];
                else         rdq <= mem[m_addr[g][9:0]];
            end
        end
        assign m_rdy[g] = (cnt == 2'd0);
        assign m_rd[g]  = rdq;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Watches the fixed-priority DUT until the chosen client's done (bounded), logging the memory accesses.
    task automatic wait_line(input bit which, output int lat, output int nre, output int nwe,
                             output logic [14:0] a0, output logic [14:0] a1,
                             output logic [31:0] w0, output logic [31:0] w1,
                             output logic [63:0] line);
        lat = -1; nre = 0; nwe = 0; a0 = '0; a1 = '0; w0 = '0; w1 = '0; line = '0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (m_re[0] || m_we[0]) begin
                if (nre + nwe == 0)      begin a0 = m_addr[0]; w0 = m_wdata[0]; end
                else if (nre + nwe == 1) begin a1 = m_addr[0]; w1 = m_wdata[0]; end
                if (m_re[0]) nre++;
                else         nwe++;
            end
            if ((which ? d_done : i_done) === 1'b1) begin
                lat  = n - 1;
                line = which ? d_rdata : i_rdata;
            end
        end
    endtask

    int          lat, nre, nwe, ndone, first_n, last_n, done_seen;
    logic [14:0] a0, a1;
    logic [31:0] w0, w1;
    logic [63:0] line, rr_dline, rr_iline;
    logic [3:0]  order;

    initial begin
        rst_n = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 15'h0020; d_addr1 = 15'h0010; d_wdata1 = '0;
        #3 rst_n = 1'b0;
        #4;
        check("rst mem_re", 64'(m_re[0]), 0);
        check("rst mem_we", 64'(m_we[0]), 0);
        check("rst mem_addr", 64'(m_addr[0]), 0);
        check("rst mem_wdata", 64'(m_wdata[0]), 0);
        check("rst dones", 64'({i_done, d_done}), 0);
        check("rst i_rdata", i_rdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: I fill at 0x0100
        i_addr = 15'h0100; i_req = 1;
        wait_line(1'b0, lat, nre, nwe, a0, a1, w0, w1, line);
        check("t1 latency", 64'(lat), 9);
        check("t1 reads", 64'(nre), 2);
        check("t1 writes", 64'(nwe), 0);
        check("t1 addr0", 64'(a0), 64'h0100);
        check("t1 addr1", 64'(a1), 64'h0101);
        check("t1 line", line, 64'h10000303_10000300);
        @(posedge clk); #1 i_req = 0;
        @(negedge clk);
        check("t1 done one cycle", 64'(i_done), 0);
        @(posedge clk); #1;

        // 2: D write-back at 0x0206
        d_we = 1; d_addr = 15'h0206; d_wdata = 64'hDEADBEEF_12345678; d_req = 1;
        wait_line(1'b1, lat, nre, nwe, a0, a1, w0, w1, line);
        check("t2 latency", 64'(lat), 9);
        check("t2 writes", 64'(nwe), 2);
        check("t2 reads", 64'(nre), 0);
        check("t2 addr0", 64'(a0), 64'h0206);
        check("t2 addr1", 64'(a1), 64'h0207);
        check("t2 wdata0", 64'(w0), 64'h12345678);
        check("t2 wdata1", 64'(w1), 64'hDEADBEEF);
        @(posedge clk); #1 d_req = 0; d_we = 0;

        // 3: simultaneous requests, fixed priority serves D first
        @(posedge clk); #1;
        d_addr = 15'h0040; i_addr = 15'h0100; d_req = 1; i_req = 1;
        wait_line(1'b1, lat, nre, nwe, a0, a1, w0, w1, line);
        check("t3 d latency", 64'(lat), 9);
        check("t3 d addr0", 64'(a0), 64'h0040);
        check("t3 d line", line, 64'h100000C3_100000C0);
        @(posedge clk); #1 d_req = 0;
        wait_line(1'b0, lat, nre, nwe, a0, a1, w0, w1, line);
        check("t3 i after d", 64'(lat), 9);
        check("t3 i addr0", 64'(a0), 64'h0100);
        check("t3 i line", line, 64'h10000303_10000300);
        @(posedge clk); #1 i_req = 0;

        // 5: odd address aligns down; request changes after grant are ignored
        @(posedge clk); #1;
        d_addr = 15'h0207; d_we = 0; d_req = 1;
        @(posedge clk); #1 d_addr = 15'h0300; d_we = 1; d_wdata = '1;
        wait_line(1'b1, lat, nre, nwe, a0, a1, w0, w1, line);
        check("t5 latency", 64'(lat), 8);
        check("t5 reads", 64'(nre), 2);
        check("t5 writes", 64'(nwe), 0);
        check("t5 addr0", 64'(a0), 64'h0206);
        check("t5 addr1", 64'(a1), 64'h0207);
        check("t5 readback", line, 64'hDEADBEEF_12345678);
        @(posedge clk); #1 d_req = 0; d_we = 0;

        // 4: round-robin, both held over four lines
        @(posedge clk); #1;
        i_req1 = 1; d_req1 = 1;
        ndone = 0; order = '0; first_n = 0; last_n = 0; rr_dline = '0; rr_iline = '0;
        for (int n = 0; n < 60 && ndone < 4; n++) begin
            @(negedge clk);
            if (i_done1 || d_done1) begin
                order = {order[2:0], d_done1};
                if (ndone == 0) first_n = n;
                last_n = n;
                if (d_done1 && rr_dline == '0) rr_dline = d_rdata1;
                if (i_done1 && rr_iline == '0) rr_iline = i_rdata1;
                ndone++;
            end
        end
        check("t4 completions", 64'(ndone), 4);
        check("t4 order DIDI", 64'(order), 64'b1010);
        check("t4 first done", 64'(first_n), 9);
        check("t4 spacing", 64'(last_n - first_n), 30);
        check("t4 d line", rr_dline, 64'h10000033_10000030);
        check("t4 i line", rr_iline, 64'h10000063_10000060);
        @(posedge clk); #1 i_req1 = 0; d_req1 = 0;
        repeat (12) @(posedge clk);
        #1;

        // 6: reset during the second-beat WAIT
        i_addr = 15'h0100; i_req = 1;
        repeat (7) @(posedge clk);
        #1;
        check("t6 pre-reset addr", 64'(m_addr[0]), 64'h0101);
        rst_n = 1'b0;
        #1;
        check("t6 rst mem_re/we", 64'({m_re[0], m_we[0]}), 0);
        check("t6 rst mem_addr", 64'(m_addr[0]), 0);
        check("t6 rst mem_wdata", 64'(m_wdata[0]), 0);
        check("t6 rst i_rdata", i_rdata, 0);
        check("t6 rst d_rdata", d_rdata, 0);
        i_req = 0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (i_done || d_done) done_seen++;
        end
        check("t6 no done in reset", 64'(done_seen), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 i_req = 1;
        wait_line(1'b0, lat, nre, nwe, a0, a1, w0, w1, line);
        check("t6 latency", 64'(lat), 9);
        check("t6 line", line, 64'h10000303_10000300);
        @(posedge clk); #1 i_req = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
